// File: rtl/datapath_pkg.sv
// Shared constants and types for the datapath control FSM.
package datapath_pkg;

   // FSM state encoding; codes 6 and 7 are unused and recover to IDLE.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FETCH = 3'd2,
      ST_EXEC  = 3'd3,
      ST_WB    = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Command opcodes
   localparam logic [1:0] OP_MOV = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   // ALU function codes
   localparam logic [2:0] S_PASSB = 3'b000;
   localparam logic [2:0] S_ADD   = 3'b001;
   localparam logic [2:0] S_SUB   = 3'b010;
   localparam logic [2:0] S_XOR   = 3'b011;

   // Operand-mux selects
   localparam logic [1:0] SEL_R0   = 2'b00;
   localparam logic [1:0] SEL_R1   = 2'b01;
   localparam logic [1:0] SEL_R2   = 2'b10;
   localparam logic [1:0] SEL_ZERO = 2'b11;

   // Register enables: bit 0..2 = R0..R2, bit 3 = Q
   localparam logic [3:0] CE_NONE = 4'b0000;
   localparam logic [3:0] CE_R0   = 4'b0001;
   localparam logic [3:0] CE_R1   = 4'b0010;
   localparam logic [3:0] CE_R2   = 4'b0100;
   localparam logic [3:0] CE_Q    = 4'b1000;
   localparam logic [3:0] CE_LOAD = 4'b0111;

   // Datapath controls applied during each EXEC cycle
   typedef struct packed {
      logic [1:0] sel;
      logic [2:0] s;
      logic       cin;
   } exec_ctrl_t;

   // MOV keeps Q = R0 by re-passing R0; the arithmetic ops combine Q with R1.
   // SUB uses Cin=1 so Q + ~B + 1 forms a two's-complement subtract.
   function automatic exec_ctrl_t exec_ctrl(input logic [1:0] op);
      exec_ctrl_t c;
      c.sel = SEL_R1;
      c.s   = S_PASSB;
      c.cin = 1'b0;
      case (op)
         OP_MOV: begin c.sel = SEL_R0; c.s = S_PASSB; end
         OP_ADD: begin c.s = S_ADD; end
         OP_SUB: begin c.s = S_SUB; c.cin = 1'b1; end
         default: begin c.s = S_XOR; end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/datapath_ctrl_iter_counter.sv
// Loadable down-counter holding the remaining EXEC repetitions.
module ctrl_iter_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             dec,
   output logic             last
);

   logic [CNT_W-1:0] cnt_reg;

   // Load max(load_value,1) so a zero count still runs one iteration; never wrap below zero.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= (load_value == '0) ? CNT_W'(1) : load_value;
      end else if (dec && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   assign last = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/datapath_ctrl.sv
// Moore control FSM sequencing one command through the 3-register/accumulator datapath.
module datapath_ctrl
   import datapath_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [1:0]       opcode,
   input  logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             M0,
   output logic             M1,
   output logic             M2,
   output logic [3:0]       ce,
   output logic [1:0]       sel,
   output logic [2:0]       s,
   output logic             Cin
);

   state_t     state_reg;
   state_t     state_next;
   logic [1:0] op_reg;
   logic       accept;
   logic       cnt_last;
   exec_ctrl_t exec_c;

   // A command is taken only while idle; start in any other state is dropped.
   assign accept = (state_reg == ST_IDLE) && start;
   assign exec_c = exec_ctrl(op_reg);

   // State register and opcode latch.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_reg <= ST_IDLE;
         op_reg    <= OP_MOV;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg <= opcode;
         end
      end
   end

   ctrl_iter_counter #(
      .CNT_W(CNT_W)
   ) u_iter (
      .clock      (clock),
      .clear      (clear),
      .load       (accept),
      .load_value (count),
      .dec        (state_reg == ST_EXEC),
      .last       (cnt_last)
   );

   // Next-state and Moore output decode; outputs depend only on state and op_reg.
   always_comb begin
      state_next = ST_IDLE;
      busy       = 1'b1;
      done       = 1'b0;
      M0         = 1'b0;
      M1         = 1'b0;
      M2         = 1'b0;
      ce         = CE_NONE;
      sel        = SEL_R0;
      s          = S_PASSB;
      Cin        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            busy       = 1'b0;
            state_next = start ? ST_LOAD : ST_IDLE;
         end
         ST_LOAD: begin
            ce         = CE_LOAD;
            state_next = ST_FETCH;
         end
         ST_FETCH: begin
            ce         = CE_Q;
            sel        = SEL_R0;
            s          = S_PASSB;
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            ce         = CE_Q;
            sel        = exec_c.sel;
            s          = exec_c.s;
            Cin        = exec_c.cin;
            state_next = cnt_last ? ST_WB : ST_EXEC;
         end
         ST_WB: begin
            M2         = 1'b1;
            ce         = CE_R2;
            state_next = ST_DONE;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule
